// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle sequencer; zero-wait latency B=3, L=5, other instructions 4 cycles.
// Stalls in FETCH/MEM until mem_ready, trapping after TIMEOUT_CYCLES; `define PERF_CNT_EN adds cycle_cnt/instret.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opCode,
  input  logic [2:0]  fun3,
  input  logic [6:0]  fun7,
  input  logic        branch_taken,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [3:0]  alu_op,
  output logic        ru_wr,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state_q, state_n;
  logic [CW-1:0] wait_cnt;
  logic          wait_clr, wait_inc, wait_expired;
  logic          set_illegal, set_timeout, retire;
  logic          is_r, is_i, is_l, is_s, is_b, is_jal, is_jalr, is_lui, is_auipc, is_legal;
  logic          unused_fun7;

  assign state        = state_q;
  assign wait_expired = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_MAX);
  assign unused_fun7  = ^{fun7[6], fun7[4:0]};

  assign is_r     = (opCode == OP_R);
  assign is_i     = (opCode == OP_I);
  assign is_l     = (opCode == OP_L);
  assign is_s     = (opCode == OP_S);
  assign is_b     = (opCode == OP_B);
  assign is_jal   = (opCode == OP_JAL);
  assign is_jalr  = (opCode == OP_JALR);
  assign is_lui   = (opCode == OP_LUI);
  assign is_auipc = (opCode == OP_AUIPC);
  assign is_legal = is_r | is_i | is_l | is_s | is_b | is_jal | is_jalr | is_lui | is_auipc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q <= state_n;
      if (wait_clr)
        wait_cnt <= '0;
      else if (wait_inc)
        wait_cnt <= wait_cnt + CW'(1);
      if (set_illegal)
        illegal <= 1'b1;
      if (set_timeout)
        timeout <= 1'b1;
    end
  end

  always_comb begin
    state_n      = state_q;
    wait_clr     = 1'b0;
    wait_inc     = 1'b0;
    set_illegal  = 1'b0;
    set_timeout  = 1'b0;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 2'd0;
    alu_op       = 4'd0;
    ru_wr        = 1'b0;
    wb_sel       = 2'd0;
    // Holding everything at its default while reset is low keeps an aborted instruction silent.
    if (reset) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_n = DECODE;
          end else if (wait_expired) begin
            state_n     = TRAP;
            set_timeout = 1'b1;
          end else begin
            wait_inc = 1'b1;
          end
        end
        DECODE: begin
          if (is_legal) begin
            state_n = EXEC;
          end else begin
            state_n     = TRAP;
            set_illegal = 1'b1;
          end
        end
        EXEC: begin
          if (is_r) begin
            alu_op = {fun7[5], fun3};
          end else if (is_i) begin
            alu_b_sel = 2'd1;
            alu_op    = {(fun3 == 3'b101) & fun7[5], fun3};
          end else if (is_lui) begin
            alu_a_sel = 2'd2;
            alu_b_sel = 2'd1;
          end else if (is_jal | is_b | is_auipc) begin
            alu_a_sel = 2'd1;
            alu_b_sel = 2'd1;
          end else begin
            alu_b_sel = 2'd1;
          end
          if (is_b) begin
            pc_we  = 1'b1;
            pc_src = branch_taken;
            retire = 1'b1;
          end else if (is_l | is_s) begin
            state_n  = MEM;
            wait_clr = 1'b1;
          end else begin
            state_n = WB;
          end
        end
        MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_s;
          if (mem_ready) begin
            if (is_s) begin
              pc_we  = 1'b1;
              retire = 1'b1;
            end else begin
              state_n = WB;
            end
          end else if (wait_expired) begin
            state_n     = TRAP;
            set_timeout = 1'b1;
          end else begin
            wait_inc = 1'b1;
          end
        end
        WB: begin
          ru_wr  = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          if (is_l) begin
            wb_sel = 2'd1;
          end else if (is_jal | is_jalr) begin
            wb_sel = 2'd2;
            pc_src = 1'b1;
          end
        end
        HALT: begin
          if (!halt_req) begin
            state_n  = FETCH;
            wait_clr = 1'b1;
          end
        end
        TRAP:    state_n = TRAP;
        default: state_n = FETCH;
      endcase
      // Instruction boundary: the only place a halt request is honoured.
      if (retire) begin
        state_n  = halt_req ? HALT : FETCH;
        wait_clr = 1'b1;
      end
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else if (state_q != TRAP) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we)
        instret <= instret + 32'd1;
    end
  end
`endif

endmodule
